// File: rtl/psr1_mon_pkg.sv
// Shared defaults and the event record layout for the pulse monitor.
package psr1_mon_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  // Interval reported for the first pulse after reset or clear
  localparam logic [63:0] FIRST = '1;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] interval;
    logic                 is_short;
  } ev_t;

  localparam int EV_W_DEF = $bits(ev_t);

endpackage

// File: rtl/psr1_pulse_mon_if.sv
// Event queue handshake between the pulse monitor (master) and its consumer (slave).
interface psr1_pulse_mon_if
  import psr1_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             ev_valid;
  logic             ev_ready;
  logic [CNT_W-1:0] ev_interval;
  logic             ev_short;

  modport master (
    output ev_valid,
    output ev_interval,
    output ev_short,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_interval,
    input  ev_short,
    output ev_ready
  );

endinterface

// File: rtl/psr1_mon_fifo.sv
// Synchronous event FIFO: count-based full/empty, registered head (no fall-through).
module psr1_mon_fifo
  import psr1_mon_pkg::*;
#(
  parameter int DATA_W = EV_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_cnt;

  logic w_do_push;
  logic w_do_pop;

  assign valid     = (r_cnt != '0);
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && valid && !clr;
  // A push into a full queue is only legal when the head leaves in the same cycle
  assign w_do_push = push && !clr && (!full || w_do_pop);
  assign dout      = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/psr1_pulse_mon.sv
// Pulse separation monitor: synchronizes pulse_in, timestamps each pulse and queues events.
// Build macro PSR1_MON_XCHK_EN additionally counts X-sampled pulses as collisions.
module psr1_pulse_mon
  import psr1_mon_pkg::*;
#(
  parameter int T_SEP      = 10,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clr,
  psr1_pulse_mon_if.master ev,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             sep_err,
  output logic             drop,
  output logic             ovf,
  output logic [7:0]       coll_cnt
);

  localparam logic [CNT_W-1:0] ALL1  = CNT_W'(FIRST);
  localparam int               EV_W  = CNT_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_icnt;
  logic             r_seen;
  logic [CNT_W-1:0] r_pcnt;
  logic             r_sep;
  logic             r_drop;
  logic             r_ovf;

  logic             w_s2_hi;
  logic             w_coll;
  logic             w_det;
  logic [CNT_W-1:0] w_interval;
  logic             w_short;
  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic             w_fifo_valid;
  logic [EV_W-1:0]  w_fifo_din;
  logic [EV_W-1:0]  w_fifo_dout;

  // Synchronizer and edge-history stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pulse_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // An unknown s2/s3 never counts as a clean high level
  assign w_s2_hi = (r_s2 === 1'b1);
`ifdef PSR1_MON_XCHK_EN
  assign w_coll  = (r_s2 === 1'bx) && (r_s3 === 1'b0);
`else
  assign w_coll  = 1'b0;
`endif
  assign w_det   = (w_s2_hi && (r_s3 !== 1'b1)) || w_coll;

  assign w_interval = r_seen ? r_icnt : ALL1;
  assign w_short    = r_seen && (r_icnt < CNT_W'(T_SEP));

  assign w_pop      = ev.ev_valid && ev.ev_ready;
  assign w_push     = w_det && !clr;
  assign w_fifo_din = {w_interval, w_short};

  // Interval, pulse count and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_icnt <= '0;
      r_seen <= 1'b0;
      r_pcnt <= '0;
      r_sep  <= 1'b0;
      r_drop <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_icnt <= w_det ? CNT_W'(1) : sat_inc_cnt(r_icnt);
      if (w_det) begin
        r_seen <= 1'b1;
        r_pcnt <= r_pcnt + CNT_W'(1);
        if (&r_pcnt) begin
          r_ovf <= 1'b1;
        end
        if (w_short) begin
          r_sep <= 1'b1;
        end
        if (w_full && !w_pop) begin
          r_drop <= 1'b1;
        end
      end
    end
  end

`ifdef PSR1_MON_XCHK_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  logic [7:0] r_coll;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_coll <= '0;
    end else if (w_coll) begin
      r_coll <= sat_inc8(r_coll);
    end
  end

  assign coll_cnt = r_coll;
`else
  assign coll_cnt = '0;
`endif

  psr1_mon_fifo #(
    .DATA_W (EV_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .valid (w_fifo_valid),
    .full  (w_full)
  );

  // Head fields read zero while the queue is empty
  assign ev.ev_valid    = w_fifo_valid;
  assign ev.ev_interval = w_fifo_valid ? w_fifo_dout[EV_W-1:1] : '0;
  assign ev.ev_short    = w_fifo_valid && w_fifo_dout[0];

  assign pulse_cnt = r_pcnt;
  assign sep_err   = r_sep;
  assign drop      = r_drop;
  assign ovf       = r_ovf;

endmodule

// File: doc/psr1_pulse_mon.md
PSR1_PULSE_MON -- requirements
Module: psr1_pulse_mon

Interface
REQ-001 SHALL have parameter T_SEP, default 10: minimum legal separation, in clk cycles, between consecutive detected pulses.
REQ-002 SHALL have parameter CNT_W, default 16: width of the interval and pulse counters.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two: event queue depth.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 pulse_in  in  1  asynchronous pulse output of an upstream confluence buffer; may carry X on collision.
REQ-008 clr  in  1  synchronous clear of counters, flags and queue.
REQ-009 ev_valid  out  1  queue head valid.
REQ-010 ev_ready  in  1  consumer accepts the queue head.
REQ-011 ev_interval  out  CNT_W  cycles since the previous detected pulse; all-ones for the first pulse.
REQ-012 ev_short  out  1  head interval < T_SEP.
REQ-013 pulse_cnt  out  CNT_W  detected pulses, modulo 2^CNT_W.
REQ-014 sep_err  out  1  sticky: any short interval.
REQ-015 drop  out  1  sticky: event lost because the queue was full.
REQ-016 ovf  out  1  sticky: pulse_cnt wrapped.
REQ-017 coll_cnt  out  8  saturating count of X-sampled pulses.

Function
REQ-018 pulse_in SHALL pass a 2-flop synchronizer (s1, s2) and then a rising-edge detector (s2=1, s3=0); det asserts exactly 1 cycle per pulse.
REQ-019 A pulse_in high across rising edge N SHALL raise det in cycle N+2; a pulse shorter than one clk period may be missed, with no error.
REQ-020 The interval counter SHALL increment each cycle, saturate at all-ones, and load 1 on det.
REQ-021 On det, SHALL push {interval, short}: interval = counter value, or all-ones if no pulse since reset/clr; short = (not first) && interval < T_SEP.
REQ-022 On det with short=1, sep_err SHALL set.
REQ-023 On det, pulse_cnt SHALL increment; on wrap from all-ones to 0, ovf SHALL set.
REQ-024 Queue handshake: pop when ev_valid && ev_ready; ev_valid=0 when empty; head stable while ev_valid && !ev_ready.
REQ-025 Full queue, det, no pop: event discarded, drop set, queue unchanged.
REQ-026 Full queue, det and pop in the same cycle: both occur; queue stays full; drop not set.
REQ-027 Empty queue, det: ev_valid SHALL rise the next cycle (no fall-through).
REQ-028 clr=1: the queue is flushed and counters, sticky flags, coll_cnt and the first-pulse marker are cleared; a coincident det is discarded. The synchronizer is not cleared.

Reset
REQ-029 rst_n=0 at a clk edge SHALL clear s1..s3, all counters and flags, the queue pointers, ev_valid and the first-pulse marker; all outputs read 0.
REQ-030 Reset mid-operation SHALL abandon queued events and partial intervals; the first pulse after release reports all-ones.

Configuration
REQ-031 With PSR1_MON_XCHK_EN defined, s2 === 1'bx with s3 = 0 SHALL count as det and increment coll_cnt, saturating at 255.
REQ-032 Without PSR1_MON_XCHK_EN, only s2 === 1'b1 is a pulse, X is treated as 0, and coll_cnt is tied to 0.

Structure
REQ-033 Package psr1_mon_pkg SHALL hold the CNT_W and FIFO_DEPTH defaults, the event struct {interval, short}, and the all-ones FIRST constant.
REQ-034 The queue SHALL be sub-module psr1_mon_fifo (synchronous FIFO, count-based full/empty, no fall-through).

Verification
REQ-035 Pulses at 0 ns and 200 ns (clk 10 ns), ev_ready=1 -> events {all-ones,0} then {20,0}; pulse_cnt=2; sep_err=0.
REQ-036 Two pulses 6 cycles apart -> second event {6,1}; sep_err=1 until clr.
REQ-037 ev_ready=0, 6 pulses 20 cycles apart -> 4 events held, drop=1; ev_ready=1 -> exactly 4 pops, first interval all-ones.
REQ-038 Queue full, det in the same cycle as a pop -> occupancy stays 4, drop=0.
REQ-039 pulse_in=X for 2 cycles -> XCHK_EN: coll_cnt=1, pulse_cnt=1; macro off: no event, coll_cnt=0.
REQ-040 rst_n=0 for 1 cycle with 3 events queued -> ev_valid=0 and all counters 0 next cycle; next pulse reports all-ones.
